// File: rtl/jtroadf_pkg.sv
// rtl/jtroadf_pkg.sv - shared jtroadf types: NVRAM read-owner tag encodings
package jtroadf_pkg;

  localparam int NV_AW = 11;

  typedef logic [1:0] tag_t;

  localparam tag_t TAG_NONE = 2'd0;
  localparam tag_t TAG_CPU  = 2'd1;
  localparam tag_t TAG_DMA  = 2'd2;

endpackage

// File: rtl/jtroadf_nvctl.sv
// rtl/jtroadf_nvctl.sv - NVRAM port arbiter: CPU (absolute priority) vs ioctl load/dump
// One-entry ioctl pending register, read-owner tag for data capture, dirty tracking.
module jtroadf_nvctl
  import jtroadf_pkg::*;
#(
  parameter int AW = NV_AW
) (
  input  logic          rst,
  input  logic          clk,
  input  logic          cpu_cen,
  input  logic          cpu_cs,
  input  logic          cpu_rnw,
  input  logic [AW-1:0] cpu_addr,
  input  logic [7:0]    cpu_dout,
  output logic [7:0]    cpu_din,
  input  logic          ioctl_ram,
  input  logic          ioctl_wr,
  input  logic          ioctl_rd,
  input  logic [AW-1:0] ioctl_addr,
  input  logic [7:0]    ioctl_dout,
  output logic [7:0]    ioctl_din,
  output logic [AW-1:0] ram_addr,
  output logic          ram_we,
  output logic [7:0]    ram_din,
  input  logic [7:0]    ram_dout,
  output logic          dma_busy,
  output logic          dma_ovf,
  output logic          dirty,
  input  logic          dirty_clr
);

  logic          cpu_gnt, cpu_wr_gnt, cpu_rd_gnt;
  logic          io_req, dma_gnt;
  logic          sel_we;
  logic [AW-1:0] sel_addr;
  logic [7:0]    sel_data;

  logic          pend_v_q, pend_v_d;
  logic          pend_we_q, pend_we_d;
  logic [AW-1:0] pend_addr_q, pend_addr_d;
  logic [7:0]    pend_data_q, pend_data_d;
  tag_t          tag_q, tag_d;
  logic [7:0]    cpu_din_q, cpu_din_d;
  logic [7:0]    ioctl_din_q, ioctl_din_d;
  logic          ovf_q, ovf_d;
  logic          dirty_q, dirty_d;

  // A fresh ioctl request bypasses the pending register so it can be served in its own cycle.
  always_comb begin
    cpu_gnt    = cpu_cen & cpu_cs;
    cpu_wr_gnt = cpu_gnt & ~cpu_rnw;
    cpu_rd_gnt = cpu_gnt & cpu_rnw;
    io_req     = ioctl_ram & (ioctl_wr | ioctl_rd);
    if (io_req) begin
      sel_we   = ioctl_wr;
      sel_addr = ioctl_addr;
      sel_data = ioctl_dout;
    end else begin
      sel_we   = pend_we_q;
      sel_addr = pend_addr_q;
      sel_data = pend_data_q;
    end
    dma_gnt = ~cpu_gnt & (io_req | pend_v_q);
  end

  always_comb begin
    ram_addr = cpu_gnt ? cpu_addr : sel_addr;
    ram_din  = cpu_gnt ? cpu_dout : sel_data;
    ram_we   = ~rst & (cpu_wr_gnt | (dma_gnt & sel_we));
    dma_busy = ~rst & (io_req | pend_v_q | (tag_q == TAG_DMA));
  end

  always_comb begin
    pend_we_d   = pend_we_q;
    pend_addr_d = pend_addr_q;
    pend_data_d = pend_data_q;
    ovf_d       = ovf_q;
    if (io_req) begin
      pend_we_d   = ioctl_wr;
      pend_addr_d = ioctl_addr;
      pend_data_d = ioctl_dout;
      if (pend_v_q) ovf_d = 1'b1;
    end
    pend_v_d = dma_gnt ? 1'b0 : (io_req | pend_v_q);

    if (cpu_rd_gnt)              tag_d = TAG_CPU;
    else if (dma_gnt && !sel_we) tag_d = TAG_DMA;
    else                         tag_d = TAG_NONE;

    cpu_din_d   = (tag_q == TAG_CPU) ? ram_dout : cpu_din_q;
    ioctl_din_d = (tag_q == TAG_DMA) ? ram_dout : ioctl_din_q;

    // A write grant in the same cycle as dirty_clr keeps the flag set.
    if (cpu_wr_gnt)     dirty_d = 1'b1;
    else if (dirty_clr) dirty_d = 1'b0;
    else                dirty_d = dirty_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_v_q    <= 1'b0;
      pend_we_q   <= 1'b0;
      pend_addr_q <= '0;
      pend_data_q <= 8'h00;
      tag_q       <= TAG_NONE;
      cpu_din_q   <= 8'h00;
      ioctl_din_q <= 8'h00;
      ovf_q       <= 1'b0;
      dirty_q     <= 1'b0;
    end else begin
      pend_v_q    <= pend_v_d;
      pend_we_q   <= pend_we_d;
      pend_addr_q <= pend_addr_d;
      pend_data_q <= pend_data_d;
      tag_q       <= tag_d;
      cpu_din_q   <= cpu_din_d;
      ioctl_din_q <= ioctl_din_d;
      ovf_q       <= ovf_d;
      dirty_q     <= dirty_d;
    end
  end

  assign cpu_din   = cpu_din_q;
  assign ioctl_din = ioctl_din_q;
  assign dma_ovf   = ovf_q;
  assign dirty     = dirty_q;

endmodule

// File: tb/tb_jtroadf_nvctl.sv
// tb/tb_jtroadf_nvctl.sv - self-checking bench for jtroadf_nvctl with a behavioural 1-cycle RAM
module tb_jtroadf_nvctl;

  localparam int AW = 11;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cpu_cen, cpu_cs, cpu_rnw;
  logic [AW-1:0] cpu_addr;
  logic [7:0]    cpu_dout, cpu_din;
  logic          ioctl_ram, ioctl_wr, ioctl_rd;
  logic [AW-1:0] ioctl_addr;
  logic [7:0]    ioctl_dout, ioctl_din;
  logic [AW-1:0] ram_addr;
  logic          ram_we;
  logic [7:0]    ram_din;
  logic [7:0]    ram_dout = 8'h00;
  logic          dma_busy, dma_ovf, dirty, dirty_clr;

  jtroadf_nvctl #(.AW(AW)) dut (
    .rst(rst), .clk(clk),
    .cpu_cen(cpu_cen), .cpu_cs(cpu_cs), .cpu_rnw(cpu_rnw),
    .cpu_addr(cpu_addr), .cpu_dout(cpu_dout), .cpu_din(cpu_din),
    .ioctl_ram(ioctl_ram), .ioctl_wr(ioctl_wr), .ioctl_rd(ioctl_rd),
    .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout), .ioctl_din(ioctl_din),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_din(ram_din), .ram_dout(ram_dout),
    .dma_busy(dma_busy), .dma_ovf(dma_ovf), .dirty(dirty), .dirty_clr(dirty_clr)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0] mem [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_din;
    ram_dout <= mem[ram_addr];
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  typedef struct {
    int         due;
    bit         dma;
    logic [7:0] data;
    string      tag;
  } exp_t;
  exp_t sb[$];

  always @(negedge clk) begin
    exp_t e;
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      e = sb.pop_front();
      if (e.due != cyc) check({e.tag, "_late"}, cyc, e.due);
      else check(e.tag, e.dma ? ioctl_din : cpu_din, e.data);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    cpu_cen = 0; cpu_cs = 0; cpu_rnw = 1;
    ioctl_ram = 0; ioctl_wr = 0; ioctl_rd = 0;
    dirty_clr = 0;
  endtask

  task automatic push_exp(input bit dma, input logic [7:0] d, input int lat, input string tag);
    exp_t e;
    e.due = cyc + lat; e.dma = dma; e.data = d; e.tag = tag;
    sb.push_back(e);
  endtask

  task automatic set_cpu(input bit rnw, input logic [AW-1:0] a, input logic [7:0] d);
    cpu_cen = 1; cpu_cs = 1; cpu_rnw = rnw; cpu_addr = a; cpu_dout = d;
  endtask

  task automatic set_io(input bit wr, input logic [AW-1:0] a, input logic [7:0] d);
    ioctl_ram = 1; ioctl_wr = wr; ioctl_rd = !wr; ioctl_addr = a; ioctl_dout = d;
  endtask

  // One CPU bus cycle followed by the idle clocks of the Q-clock spacing.
  task automatic cpu_access(input bit rnw, input logic [AW-1:0] a, input logic [7:0] d,
                            input logic [7:0] exp, input string tag);
    set_cpu(rnw, a, d);
    if (rnw) push_exp(1'b0, exp, 2, tag);
    @(negedge clk);
    check({tag, "_we"}, ram_we, !rnw);
    check({tag, "_addr"}, ram_addr, a);
    tick();
    idle_inputs();
    repeat (3) tick();
  endtask

  initial begin
    idle_inputs();
    cpu_addr = '0; cpu_dout = 8'h00; ioctl_addr = '0; ioctl_dout = 8'h00;
    tick();
    @(negedge clk);
    check("rst_cpu_din", cpu_din, 8'h00);
    check("rst_ioctl_din", ioctl_din, 8'h00);
    check("rst_busy", dma_busy, 1'b0);
    check("rst_ovf", dma_ovf, 1'b0);
    check("rst_dirty", dirty, 1'b0);
    check("rst_we", ram_we, 1'b0);
    tick();
    rst = 0;
    tick();

    // CPU write then read-back four clocks later
    set_cpu(1'b0, 11'h123, 8'h5A);
    @(negedge clk);
    check("cw_din", ram_din, 8'h5A);
    tick(); idle_inputs(); repeat (3) tick();
    cpu_access(1'b1, 11'h123, 8'h00, 8'h5A, "cr_123");
    check("dirty_after_wr", dirty, 1'b1);

    // dirty_clr coincident with a write, then alone
    dirty_clr = 1;
    cpu_access(1'b0, 11'h100, 8'h77, 8'h00, "cw_clr");
    check("dirty_clr_wr", dirty, 1'b1);
    dirty_clr = 1;
    tick(); idle_inputs();
    @(negedge clk);
    check("dirty_clr_only", dirty, 1'b0);
    tick();

    // ioctl write with no CPU activity
    set_io(1'b1, 11'h7FF, 8'hC3);
    @(negedge clk);
    check("iw_we", ram_we, 1'b1);
    check("iw_addr", ram_addr, 11'h7FF);
    check("iw_din", ram_din, 8'hC3);
    check("iw_busy0", dma_busy, 1'b1);
    tick(); idle_inputs();
    @(negedge clk);
    check("iw_busy1", dma_busy, 1'b0);
    check("iw_no_dirty", dirty, 1'b0);
    tick();
    cpu_access(1'b1, 11'h7FF, 8'h00, 8'hC3, "cr_7ff");

    // same-cycle CPU read and ioctl read
    cpu_access(1'b0, 11'h010, 8'h11, 8'h00, "cw_010");
    cpu_access(1'b0, 11'h020, 8'h22, 8'h00, "cw_020");
    set_cpu(1'b1, 11'h010, 8'h00);
    set_io(1'b0, 11'h020, 8'h00);
    push_exp(1'b0, 8'h11, 2, "both_cpu");
    push_exp(1'b1, 8'h22, 3, "both_dma");
    push_exp(1'b0, 8'h11, 3, "both_cpu_hold");
    @(negedge clk);
    check("both_n_addr", ram_addr, 11'h010);
    check("both_n_busy", dma_busy, 1'b1);
    tick(); idle_inputs();
    @(negedge clk);
    check("both_n1_addr", ram_addr, 11'h020);
    check("both_n1_we", ram_we, 1'b0);
    tick();
    @(negedge clk);
    check("both_n2_busy", dma_busy, 1'b1);
    tick();
    @(negedge clk);
    check("both_n3_busy", dma_busy, 1'b0);
    repeat (3) tick();

    // two ioctl writes both colliding with CPU reads: overrun
    set_cpu(1'b1, 11'h123, 8'h00);
    set_io(1'b1, 11'h040, 8'hAA);
    push_exp(1'b0, 8'h5A, 2, "ovf_cr0");
    @(negedge clk);
    check("ovf_n_we", ram_we, 1'b0);
    tick();
    set_io(1'b1, 11'h040, 8'hBB);
    @(negedge clk);
    check("ovf_n1_we", ram_we, 1'b0);
    check("ovf_n1_flag", dma_ovf, 1'b0);
    tick(); idle_inputs();
    @(negedge clk);
    check("ovf_flag", dma_ovf, 1'b1);
    check("ovf_n2_we", ram_we, 1'b1);
    check("ovf_n2_din", ram_din, 8'hBB);
    tick();
    @(negedge clk);
    check("ovf_busy_done", dma_busy, 1'b0);
    repeat (3) tick();
    cpu_access(1'b1, 11'h040, 8'h00, 8'hBB, "cr_040");
    check("ovf_sticky", dma_ovf, 1'b1);

    // reset between a read grant and its capture, with an ioctl write pending
    set_io(1'b1, 11'h050, 8'h44);
    tick(); idle_inputs(); repeat (3) tick();
    set_cpu(1'b1, 11'h123, 8'h00);
    set_io(1'b1, 11'h050, 8'hEE);
    tick();
    idle_inputs();
    rst = 1;
    @(negedge clk);
    check("mid_rst_cpu_din", cpu_din, 8'h00);
    check("mid_rst_we", ram_we, 1'b0);
    check("mid_rst_busy", dma_busy, 1'b0);
    tick(); tick();
    rst = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("post_rst_we", ram_we, 1'b0);
      tick();
    end
    check("post_rst_cpu_din", cpu_din, 8'h00);
    check("post_rst_ovf", dma_ovf, 1'b0);
    cpu_access(1'b1, 11'h050, 8'h00, 8'h44, "cr_050");

    for (int i = 0; i < 20 && sb.size() > 0; i++) tick();
    check("sb_drain", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
